// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two SRAM requesters, the arbiter and the external SRAM pins.
// The arbiter uses the slave view; the requester/SRAM side uses the master view.
interface sram_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              A_Req;
   logic              A_WE;
   logic [ADDR_W-1:0] A_Addr;
   logic [DATA_W-1:0] A_WData;
   logic [DATA_W-1:0] A_RData;
   logic              A_Done;

   logic              B_Req;
   logic              B_WE;
   logic [ADDR_W-1:0] B_Addr;
   logic [DATA_W-1:0] B_WData;
   logic [DATA_W-1:0] B_RData;
   logic              B_Done;

   logic [ADDR_W-1:0] SRAM_Addr;
   logic [DATA_W-1:0] Data_to_SRAM;
   logic              SRAM_Drive;
   logic [DATA_W-1:0] Data_from_SRAM;
   logic              Mem_CE;
   logic              Mem_OE;
   logic              Mem_WE;
   logic              Mem_UB;
   logic              Mem_LB;
   logic              Busy;
   logic              Grant;

   modport slave (
      input  A_Req, A_WE, A_Addr, A_WData,
      input  B_Req, B_WE, B_Addr, B_WData,
      input  Data_from_SRAM,
      output A_RData, A_Done, B_RData, B_Done,
      output SRAM_Addr, Data_to_SRAM, SRAM_Drive,
      output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
      output Busy, Grant
   );

   modport master (
      output A_Req, A_WE, A_Addr, A_WData,
      output B_Req, B_WE, B_Addr, B_WData,
      output Data_from_SRAM,
      input  A_RData, A_Done, B_RData, B_Done,
      input  SRAM_Addr, Data_to_SRAM, SRAM_Drive,
      input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
      input  Busy, Grant
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and fixed-length access sequencer for the shared async SRAM.
// One access at a time: IDLE -> ACCESS (ACCESS_CYCLES) -> DONE (Done pulse, strobes off) -> IDLE.
module sram_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 2
) (
   input logic          Clk,
   input logic          Reset,
   sram_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              last_q, last_d;

   logic any_req;
   logic pick_b;
   logic in_access;

   // On a tie the port that did not win last time gets the grant.
   assign any_req   = bus.A_Req | bus.B_Req;
   assign pick_b    = bus.B_Req & (~bus.A_Req | ~last_q);
   assign in_access = (state_q == ACCESS);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      last_d    = last_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               last_d  = pick_b;
               we_d    = pick_b ? bus.B_WE    : bus.A_WE;
               addr_d  = pick_b ? bus.B_Addr  : bus.A_Addr;
               wdata_d = pick_b ? bus.B_WData : bus.A_WData;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) begin
                  if (last_q) b_rdata_d = bus.Data_from_SRAM;
                  else        a_rdata_d = bus.Data_from_SRAM;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         last_q    <= last_d;
      end
   end

   // Strobes decode straight from registered state, so DONE always has Mem_WE high.
   assign bus.Mem_CE       = ~in_access;
   assign bus.Mem_OE       = ~(in_access & ~we_q);
   assign bus.Mem_WE       = ~(in_access & we_q);
   assign bus.SRAM_Drive   = in_access & we_q;
   assign bus.Mem_UB       = 1'b0;
   assign bus.Mem_LB       = 1'b0;
   assign bus.SRAM_Addr    = addr_q;
   assign bus.Data_to_SRAM = wdata_q;
   assign bus.A_RData      = a_rdata_q;
   assign bus.B_RData      = b_rdata_q;
   assign bus.A_Done       = (state_q == DONE) & ~last_q;
   assign bus.B_Done       = (state_q == DONE) &  last_q;
   assign bus.Busy         = (state_q != IDLE);
   assign bus.Grant        = last_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations (main build ACCESS_CYCLES=2, second build =1).
module tb_sram_arbiter;
   localparam int AW = 20;
   localparam int DW = 16;
   localparam int AC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
      .Clk(clk), .Reset(rst), .bus(bus0)
   );
   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) dut1 (
      .Clk(clk), .Reset(rst), .bus(bus1)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // External SRAM behaviour (environment, not the reference model)
   logic [DW-1:0] sram [0:255];
   always @(posedge clk)
      if (!bus0.Mem_CE && !bus0.Mem_WE && bus0.SRAM_Drive)
         sram[bus0.SRAM_Addr[7:0]] <= bus0.Data_to_SRAM;
   assign bus0.Data_from_SRAM = !bus0.Mem_OE ? sram[bus0.SRAM_Addr[7:0]] : 16'hDEAD;
   assign bus1.Data_from_SRAM = 16'h5A5A;

   // Reference model: memory contents plus at most one in-flight transaction
   logic [DW-1:0] mmem [0:255];
   bit            mon_en = 1'b0;
   bit            m_busy, m_port, m_we, m_last;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rd [2];
   int            m_k;

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i] = 16'h0000;
         mmem[i] = 16'h0000;
      end
      sram[8'h10] = 16'h1234;  mmem[8'h10] = 16'h1234;
      sram[8'h30] = 16'h9999;  mmem[8'h30] = 16'h9999;
   end

   always @(posedge clk) begin
      bit acc, dn;
      if (rst) begin
         m_busy = 0; m_last = 1; m_k = 0; m_addr = '0; m_wdata = '0;
         m_rd[0] = '0; m_rd[1] = '0; mon_en = 1;
      end else if (!m_busy) begin
         if (bus0.A_Req || bus0.B_Req) begin
            m_port  = (bus0.A_Req && bus0.B_Req) ? !m_last : bus0.B_Req;
            m_last  = m_port;
            m_we    = m_port ? bus0.B_WE    : bus0.A_WE;
            m_addr  = m_port ? bus0.B_Addr  : bus0.A_Addr;
            m_wdata = m_port ? bus0.B_WData : bus0.A_WData;
            m_busy  = 1; m_k = 0;
         end
      end else begin
         m_k++;
         if (m_k == AC) begin
            if (m_we) mmem[m_addr[7:0]] = m_wdata;
            else      m_rd[m_port] = mmem[m_addr[7:0]];
         end else if (m_k == AC + 1) begin
            m_busy = 0;
         end
      end
      #1;
      if (mon_en) begin
         acc = m_busy && (m_k < AC);
         dn  = m_busy && (m_k == AC);
         // {CE,OE,WE,Drive,Busy,Grant,A_Done,B_Done}
         chk("ctrl", {bus0.Mem_CE, bus0.Mem_OE, bus0.Mem_WE, bus0.SRAM_Drive, bus0.Busy,
                      bus0.Grant, bus0.A_Done, bus0.B_Done},
             {!acc, !(acc && !m_we), !(acc && m_we), acc && m_we, m_busy, m_last,
              dn && !m_port, dn && m_port});
         chk("SRAM_Addr", 32'(bus0.SRAM_Addr), 32'(m_addr));
         chk("Data_to_SRAM", 32'(bus0.Data_to_SRAM), 32'(m_wdata));
         chk("A_RData", 32'(bus0.A_RData), 32'(m_rd[0]));
         chk("B_RData", 32'(bus0.B_RData), 32'(m_rd[1]));
         chk("done_excl", 32'(bus0.A_Done & bus0.B_Done), 32'd0);
         chk("UB_LB", {30'd0, bus0.Mem_UB, bus0.Mem_LB}, 32'd0);
      end
   end

   task automatic set_port(input bit port, input bit req, input bit we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      if (!port) begin
         bus0.A_Req = req; bus0.A_WE = we; bus0.A_Addr = addr; bus0.A_WData = wd;
      end else begin
         bus0.B_Req = req; bus0.B_WE = we; bus0.B_Addr = addr; bus0.B_WData = wd;
      end
   endtask

   // One access from an idle arbiter. lat counts edges from the grant edge (=1) to the
   // edge after which Done is visible; Req drops right after the grant edge.
   task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit perturb,
                         output int lat, output int oe_lo, output int we_lo, output bit addr_ok);
      bit done;
      @(negedge clk);
      set_port(port, 1'b1, we, addr, wd);
      @(posedge clk); #2;
      set_port(port, 1'b0, we, perturb ? (addr ^ 20'h20) : addr, perturb ? ~wd : wd);
      lat = 1; oe_lo = 0; we_lo = 0; addr_ok = 1; done = 0;
      while (!done && lat < 20) begin
         if (!bus0.Mem_OE) oe_lo++;
         if (!bus0.Mem_WE) we_lo++;
         if (!bus0.Mem_CE && bus0.SRAM_Addr !== addr) addr_ok = 0;
         if (port ? bus0.B_Done : bus0.A_Done) done = 1;
         else begin
            @(posedge clk); #2;
            lat++;
         end
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
   endtask

   initial begin
      int  lat, oe, wl, n;
      bit  aok;
      bit  order [$];
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  lat, oe, wl, n, bothd;
      bit  aok;
      bit  order [$];
      bus0.A_Req = 0; bus0.A_WE = 0; bus0.A_Addr = '0; bus0.A_WData = '0;
      bus0.B_Req = 0; bus0.B_WE = 0; bus0.B_Addr = '0; bus0.B_WData = '0;
      bus1.A_Req = 0; bus1.A_WE = 0; bus1.A_Addr = '0; bus1.A_WData = '0;
      bus1.B_Req = 0; bus1.B_WE = 0; bus1.B_Addr = '0; bus1.B_WData = '0;
      rst = 1;
      repeat (3) @(negedge clk);
      chk("rst_strobes", {29'd0, bus0.Mem_CE, bus0.Mem_OE, bus0.Mem_WE}, 32'h7);
      chk("rst_busy_grant", {30'd0, bus0.Busy, bus0.Grant}, 32'h1);
      chk("rst_rdata", {bus0.A_RData, bus0.B_RData}, 32'h0);
      rst = 0;

      // A read of 0x10
      access(0, 0, 20'h00010, 16'h0, 0, lat, oe, wl, aok);
      chk("t1_lat", lat, 3);
      chk("t1_oe_cycles", oe, 2);
      chk("t1_we_cycles", wl, 0);
      chk("t1_A_RData", 32'(bus0.A_RData), 32'h1234);
      chk("t1_B_RData", 32'(bus0.B_RData), 32'h0);

      // B write 0xBEEF to 0x20, then read it back
      access(1, 1, 20'h00020, 16'hBEEF, 0, lat, oe, wl, aok);
      chk("t2_we_cycles", wl, 2);
      chk("t2_oe_cycles", oe, 0);
      chk("t2_addr", aok, 1);
      chk("t2_lat", lat, 3);
      access(1, 0, 20'h00020, 16'h0, 0, lat, oe, wl, aok);
      chk("t2_B_RData", 32'(bus0.B_RData), 32'hBEEF);
      chk("t2_A_RData_kept", 32'(bus0.A_RData), 32'h1234);

      // Address change and Req drop during ACCESS are ignored
      access(0, 0, 20'h00010, 16'h0, 1, lat, oe, wl, aok);
      chk("t4_addr_stable", aok, 1);
      chk("t4_lat", lat, 3);
      chk("t4_A_RData", 32'(bus0.A_RData), 32'h1234);

      // Both ports held high after reset: A, B, A, B
      do_reset();
      @(negedge clk);
      set_port(0, 1, 0, 20'h00010, 16'h0);
      set_port(1, 1, 1, 20'h00040, 16'h7777);
      n = 0; bothd = 0;
      while (order.size() < 4 && n < 60) begin
         @(negedge clk); n++;
         if (bus0.A_Done && bus0.B_Done) bothd++;
         if (bus0.A_Done) order.push_back(1'b0);
         if (bus0.B_Done) order.push_back(1'b1);
      end
      set_port(0, 0, 0, 20'h00010, 16'h0);
      set_port(1, 0, 1, 20'h00040, 16'h7777);
      chk("t3_count", order.size(), 4);
      while (order.size() < 4) order.push_back(1'b0);
      chk("t3_order", {28'd0, order[0], order[1], order[2], order[3]}, 32'b0101);
      chk("t3_both_done", bothd, 0);
      repeat (6) @(negedge clk);

      // Reset in the second ACCESS cycle of a write
      @(negedge clk);
      set_port(1, 1, 1, 20'h00050, 16'hCAFE);
      @(posedge clk); #2;
      set_port(1, 0, 1, 20'h00050, 16'hCAFE);
      @(posedge clk); #2;
      chk("t5_in_access", {31'd0, bus0.Mem_WE}, 32'd0);
      rst = 1;
      @(posedge clk); #2;
      chk("t5_strobes", {28'd0, bus0.Mem_CE, bus0.Mem_OE, bus0.Mem_WE, bus0.SRAM_Drive}, 32'hE);
      chk("t5_busy", {31'd0, bus0.Busy}, 32'd0);
      @(negedge clk); rst = 0;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus0.A_Done || bus0.B_Done) n++;
      end
      chk("t5_no_done", n, 0);

      // ACCESS_CYCLES=1 build: A read
      @(negedge clk);
      bus1.A_Req = 1; bus1.A_Addr = 20'h00010;
      @(posedge clk); #2;
      bus1.A_Req = 0;
      lat = 1; oe = 0; aok = 0;
      while (!aok && lat < 20) begin
         if (!bus1.Mem_OE) oe++;
         if (bus1.A_Done) aok = 1;
         else begin
            @(posedge clk); #2;
            lat++;
         end
      end
      chk("t6_done_seen", aok, 1);
      chk("t6_lat", lat, 2);
      chk("t6_oe_cycles", oe, 1);
      chk("t6_A_RData", 32'(bus1.A_RData), 32'h5A5A);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
